// File: rtl/decode_stage_skid_register.sv
// ---------------------------------------------------------------------------
// decode_stage_skid_register
//
// Decode/execute pipeline register with a valid/ready handshake. A 2-entry
// skid buffer (main + skid) lets IN_READY depend on the state register only,
// so OUT_READY never reaches IN_READY combinationally. FLUSH discards all held
// entries and can optionally zero the payload. STALL_COUNT is a saturating
// count of back-pressured cycles for performance monitoring.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   FLUSH        discard all held entries (mispredict / trap)
//   IN_VALID     upstream decode offers IN_DATA
//   IN_READY     block can accept a payload this cycle (state-only decode)
//   IN_DATA      payload from decode
//   OUT_VALID    OUT_DATA holds a valid payload
//   OUT_READY    execute consumes OUT_DATA this cycle
//   OUT_DATA     payload to execute, straight from the main register
//   OCCUPANCY    number of held entries, 0..2
//   STALL_COUNT  saturating count of OUT_VALID & !OUT_READY & !FLUSH cycles
// ---------------------------------------------------------------------------
module decode_stage_skid_register #(
  parameter int unsigned DATA_WIDTH         = 160,
  parameter bit          FLUSH_ZERO_PAYLOAD = 1'b1,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_WIDTH-1:0]  IN_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_WIDTH-1:0]  OUT_DATA,
  output logic [1:0]             OCCUPANCY,
  output logic [COUNT_WIDTH-1:0] STALL_COUNT
);

  // Encoding equals the entry count, so OCCUPANCY is the state register
  // itself and IN_READY is the inverse of a single state bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_WIDTH-1:0]  main_q;
  logic [DATA_WIDTH-1:0]  skid_q;
  logic [COUNT_WIDTH-1:0] stall_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic zero_payload;

  assign OUT_VALID   = (state_q != EMPTY);
  assign IN_READY    = ~state_q[1];
  assign OCCUPANCY   = state_q;
  assign OUT_DATA    = main_q;
  assign STALL_COUNT = stall_q;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    zero_payload   = 1'b0;
    if (FLUSH) begin
      state_d      = EMPTY;
      zero_payload = FLUSH_ZERO_PAYLOAD;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || zero_payload) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= IN_DATA;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= IN_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
    end else if (OUT_VALID && !OUT_READY && !FLUSH && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage_skid_register.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_skid_register
//
// Three instances share one stimulus stream: default parameters (A),
// FLUSH_ZERO_PAYLOAD=0 (B) and COUNT_WIDTH=3 (C). A queue model of the
// two-entry buffer predicts handshakes; payloads are pushed on accept and
// popped/compared on consume.
// ---------------------------------------------------------------------------
module tb_decode_stage_skid_register;

  localparam int unsigned DW = 160;

  logic          CLK;
  logic          RST;
  logic          FLUSH;
  logic          IN_VALID;
  logic [DW-1:0] IN_DATA;
  logic          OUT_READY;

  logic          in_ready_a, in_ready_b, in_ready_c;
  logic          out_valid_a, out_valid_b, out_valid_c;
  logic [DW-1:0] out_data_a, out_data_b, out_data_c;
  logic [1:0]    occ_a, occ_b, occ_c;
  logic [15:0]   stall_a, stall_b;
  logic [2:0]    stall_c;

  decode_stage_skid_register #(
    .DATA_WIDTH(DW), .FLUSH_ZERO_PAYLOAD(1'b1), .COUNT_WIDTH(16)
  ) u_a (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready_a), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .OUT_DATA(out_data_a),
    .OCCUPANCY(occ_a), .STALL_COUNT(stall_a)
  );

  decode_stage_skid_register #(
    .DATA_WIDTH(DW), .FLUSH_ZERO_PAYLOAD(1'b0), .COUNT_WIDTH(16)
  ) u_b (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready_b), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .OUT_DATA(out_data_b),
    .OCCUPANCY(occ_b), .STALL_COUNT(stall_b)
  );

  decode_stage_skid_register #(
    .DATA_WIDTH(DW), .FLUSH_ZERO_PAYLOAD(1'b1), .COUNT_WIDTH(3)
  ) u_c (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready_c), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid_c), .OUT_READY(OUT_READY), .OUT_DATA(out_data_c),
    .OCCUPANCY(occ_c), .STALL_COUNT(stall_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    assert (!$isunknown({RST, FLUSH, IN_VALID, OUT_READY}))
      else $error("X on a control input");
  end

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] sb_q[$];
  logic [15:0]   m_stall16;
  logic [2:0]    m_stall3;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: model evaluates the inputs already driven, then the edge,
  // then all instances are compared against the model 1 time unit later.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    logic          m_ov;
    logic          m_ir;
    logic [DW-1:0] exp;
    RST = r; FLUSH = f; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
    #1;
    if (r) begin
      sb_q.delete();
      m_stall16 = '0;
      m_stall3  = '0;
    end else begin
      m_ov = (sb_q.size() > 0);
      m_ir = (sb_q.size() < 2);
      if (m_ov && !ordy && !f) begin
        if (m_stall16 != '1) m_stall16++;
        if (m_stall3 != '1) m_stall3++;
      end
      if (m_ov && ordy) begin
        exp = sb_q.pop_front();
        check("out_data_a", out_data_a, exp);
        check("out_data_b", out_data_b, exp);
        check("out_data_c", out_data_c, exp);
      end
      if (f) sb_q.delete();
      else if (iv && m_ir) sb_q.push_back(d);
    end
    @(posedge CLK);
    #1;
    check("in_ready_a", in_ready_a, (sb_q.size() < 2));
    check("out_valid_a", out_valid_a, (sb_q.size() > 0));
    check("occ_a", occ_a, sb_q.size());
    check("occ_b", occ_b, sb_q.size());
    check("occ_c", occ_c, sb_q.size());
    check("stall_a", stall_a, m_stall16);
    check("stall_b", stall_b, m_stall16);
    check("stall_c", stall_c, m_stall3);
  endtask

  initial begin
    logic [DW-1:0] rd;
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    m_stall16 = '0;
    m_stall3  = '0;

    // Reset for two cycles
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_data_a", out_data_a, '0);
    check("rst_out_data_b", out_data_b, '0);
    check("rst_occ", occ_a, 2'd0);
    check("rst_stall", stall_a, 16'd0);

    // Streaming 1..4 with OUT_READY high
    for (int unsigned k = 1; k <= 4; k++) begin
      step(0, 0, 1, DW'(k), 1);
      check("stream_data", out_data_a, DW'(k));
      check("stream_occ", occ_a, 2'd1);
      check("stream_in_ready", in_ready_a, 1'b1);
    end
    step(0, 0, 0, '0, 1);
    check("stream_drained", out_valid_a, 1'b0);

    // Back-pressure: 0xA, 0xB held, 5 idle cycles
    step(0, 0, 1, DW'('hA), 0);
    step(0, 0, 1, DW'('hB), 0);
    check("bp_occ_full", occ_a, 2'd2);
    check("bp_in_ready", in_ready_a, 1'b0);
    check("bp_head", out_data_a, DW'('hA));
    for (int unsigned k = 0; k < 5; k++) step(0, 0, 0, '0, 0);
    check("bp_stall6", stall_a, 16'd6);
    step(0, 0, 0, '0, 1);
    check("bp_in_ready_back", in_ready_a, 1'b1);
    check("bp_second", out_data_a, DW'('hB));
    step(0, 0, 0, '0, 1);
    check("bp_empty", out_valid_a, 1'b0);

    // Flush while FULL with a simultaneous offer of 0xC
    step(0, 0, 1, DW'('hA), 0);
    step(0, 0, 1, DW'('hB), 0);
    step(0, 1, 1, DW'('hC), 0);
    check("fl_out_valid", out_valid_a, 1'b0);
    check("fl_occ", occ_a, 2'd0);
    check("fl_zero_a", out_data_a, '0);
    check("fl_keep_b", out_data_b, DW'('hA));
    check("fl_stall_kept", stall_a, 16'd7);
    for (int unsigned k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
    check("fl_no_c", out_valid_a, 1'b0);

    // No-zero instance keeps the payload across FLUSH
    step(0, 0, 1, DW'('h55), 0);
    step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    check("nz_out_valid_b", out_valid_b, 1'b0);
    check("nz_data_b", out_data_b, DW'('h55));
    check("nz_data_a", out_data_a, '0);
    check("nz_stall_c_sat", stall_c, 3'd7);

    // Saturation at 7 then reset mid-stall with both entries held
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, DW'('h1), 0);
    for (int unsigned k = 0; k < 10; k++) step(0, 0, 0, '0, 0);
    check("sat_c", stall_c, 3'd7);
    check("sat_a", stall_a, 16'd10);
    step(0, 0, 1, DW'('h2), 0);
    check("sat_occ2", occ_c, 2'd2);
    step(1, 0, 1, DW'('h3), 1);
    check("rst_mid_occ", occ_c, 2'd0);
    check("rst_mid_stall", stall_c, 3'd0);
    check("rst_mid_data", out_data_c, '0);
    check("rst_mid_in_ready", in_ready_c, 1'b1);
    check("rst_mid_out_valid", out_valid_c, 1'b0);

    // Random traffic
    for (int unsigned k = 0; k < 400; k++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1), rd, ($urandom_range(0, 3) != 0));
    end
    for (int unsigned k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
    check("final_empty", out_valid_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
